// File: rtl/cam_core.sv
// Transposed-storage CAM: row k of the table holds one bit per entry currently storing key k.
// Writes take two cycles (clear old key bit, then set new key bit); searches are pipelined with a latency of two cycles.
module cam_core #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       er_en,
  input  logic [ADDR_WIDTH-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       ready,
  input  logic                       srch_en,
  input  logic [DATA_WIDTH-1:0]      srch_data,
  output logic                       srch_valid,
  output logic [2**ADDR_WIDTH-1:0]   match_vec,
  output logic                       match,
  output logic [ADDR_WIDTH-1:0]      match_addr
);

  localparam int NROWS = 2**DATA_WIDTH;
  localparam int NENT  = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {INIT, IDLE, CLR_OLD, SET_NEW} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] wa_q, wa_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic [NENT-1:0]       vld_q, vld_d;
  logic [DATA_WIDTH-1:0] key_q [NENT];
  logic [NENT-1:0]       mem_q [NROWS];

  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_row;
  logic [NENT-1:0]       mem_wdata;
  logic                  key_we;

  logic                  ready_q, ready_d;
  logic                  s1_vld_q, s1_vld_d;
  logic [NENT-1:0]       s1_row_q, s1_row_d;
  logic                  srch_valid_q, srch_valid_d;
  logic [NENT-1:0]       match_vec_q, match_vec_d;
  logic                  match_q, match_d;
  logic [ADDR_WIDTH-1:0] match_addr_q, match_addr_d;

  // Control path: at most one row of the table is written per cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wa_d      = wa_q;
    wd_d      = wd_q;
    vld_d     = vld_q;
    mem_we    = 1'b0;
    mem_row   = cnt_q;
    mem_wdata = '0;
    key_we    = 1'b0;
    case (state_q)
      INIT: begin
        mem_we  = 1'b1;
        mem_row = cnt_q;
        cnt_d   = cnt_q + 1'b1;
        if (&cnt_q) state_d = IDLE;
      end
      IDLE: begin
        if (wr_en) begin
          wa_d    = wr_addr;
          wd_d    = wr_data;
          state_d = CLR_OLD;
        end else if (er_en) begin
          vld_d[wr_addr] = 1'b0;
          if (vld_q[wr_addr]) begin
            mem_we             = 1'b1;
            mem_row            = key_q[wr_addr];
            mem_wdata          = mem_q[key_q[wr_addr]];
            mem_wdata[wr_addr] = 1'b0;
          end
        end
      end
      CLR_OLD: begin
        if (vld_q[wa_q]) begin
          mem_we          = 1'b1;
          mem_row         = key_q[wa_q];
          mem_wdata       = mem_q[key_q[wa_q]];
          mem_wdata[wa_q] = 1'b0;
        end
        state_d = SET_NEW;
      end
      SET_NEW: begin
        mem_we          = 1'b1;
        mem_row         = wd_q;
        mem_wdata       = mem_q[wd_q];
        mem_wdata[wa_q] = 1'b1;
        key_we          = 1'b1;
        vld_d[wa_q]     = 1'b1;
        state_d         = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // Search path reads the row before this cycle's table update lands.
  always_comb begin
    s1_vld_d     = srch_en && (state_q != INIT);
    s1_row_d     = s1_vld_d ? mem_q[srch_data] : s1_row_q;
    srch_valid_d = s1_vld_q;
    match_vec_d  = match_vec_q;
    match_d      = match_q;
    match_addr_d = match_addr_q;
    if (s1_vld_q) begin
      match_vec_d  = s1_row_q;
      match_d      = |s1_row_q;
      match_addr_d = '0;
      for (int unsigned i = NENT; i > 0; i--) begin
        if (s1_row_q[i-1]) match_addr_d = ADDR_WIDTH'(i - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      vld_q        <= '0;
      ready_q      <= 1'b0;
      s1_vld_q     <= 1'b0;
      srch_valid_q <= 1'b0;
      match_vec_q  <= '0;
      match_q      <= 1'b0;
      match_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vld_q        <= vld_d;
      ready_q      <= ready_d;
      s1_vld_q     <= s1_vld_d;
      srch_valid_q <= srch_valid_d;
      match_vec_q  <= match_vec_d;
      match_q      <= match_d;
      match_addr_q <= match_addr_d;
    end
  end

  // Table, shadow keys and datapath latches need no reset; INIT and the valid bits cover them.
  always_ff @(posedge clk) begin
    wa_q     <= wa_d;
    wd_q     <= wd_d;
    s1_row_q <= s1_row_d;
    if (mem_we && !rst) mem_q[mem_row] <= mem_wdata;
    if (key_we && !rst) key_q[wa_q] <= wd_q;
  end

  assign ready      = ready_q;
  assign srch_valid = srch_valid_q;
  assign match_vec  = match_vec_q;
  assign match      = match_q;
  assign match_addr = match_addr_q;

endmodule

// File: tb/tb_cam_core.sv
// Directed and random checks of cam_core against an entry-level model (key per entry plus busy/INIT timing).
module tb_cam_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic        er_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [3:0]  wr_data = '0;
  logic        ready;
  logic        srch_en = 1'b0;
  logic [3:0]  srch_data = '0;
  logic        srch_valid;
  logic [15:0] match_vec;
  logic        match;
  logic [3:0]  match_addr;

  always #5 clk = ~clk;

  cam_core #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .er_en(er_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .ready(ready), .srch_en(srch_en), .srch_data(srch_data),
    .srch_valid(srch_valid), .match_vec(match_vec), .match(match), .match_addr(match_addr)
  );

  int total = 0;
  int bad   = 0;

  // Model: which key each entry holds, plus how long the DUT stays busy.
  logic [3:0]  mkey [16];
  logic        mval [16];
  int          init_left = 16;
  int          busy = 0;
  logic [3:0]  pa, pd;
  logic        p1_v = 1'b0;
  logic [15:0] p1_vec = '0;
  logic        e_v = 1'b0;
  logic [15:0] e_vec = '0;

  function automatic logic [15:0] lookup(input logic [3:0] k);
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++) if (mval[i] && mkey[i] == k) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [3:0] lowest(input logic [15:0] v);
    logic [15:0] iso;
    iso = v & (~v + 16'd1);
    return 4'($clog2(iso));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; wr_en = 1'b0; er_en = 1'b0; srch_en = 1'b0;
  endtask

  task automatic tick();
    logic [15:0] v;
    v = lookup(srch_data);
    if (rst) begin
      e_v = 1'b0; e_vec = '0; p1_v = 1'b0;
    end else begin
      e_v = p1_v;
      if (p1_v) e_vec = p1_vec;
      p1_v   = srch_en && (init_left == 0);
      p1_vec = v;
    end
    if (rst) begin
      init_left = 16; busy = 0;
      for (int i = 0; i < 16; i++) mval[i] = 1'b0;
    end else if (init_left > 0) init_left--;
    else if (busy == 2) begin mval[pa] = 1'b0; busy = 1; end
    else if (busy == 1) begin mkey[pa] = pd; mval[pa] = 1'b1; busy = 0; end
    else if (wr_en) begin pa = wr_addr; pd = wr_data; busy = 2; end
    else if (er_en) mval[wr_addr] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready", ready, (init_left == 0 && busy == 0));
    chk("srch_valid", srch_valid, e_v);
    if (e_v || rst) begin
      chk("match_vec", match_vec, e_vec);
      chk("match", match, |e_vec);
      chk("match_addr", match_addr, lowest(e_vec));
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d; tick();
    wr_en = 1'b0; tick(); tick();
  endtask

  task automatic do_search(input logic [3:0] k);
    srch_en = 1'b1; srch_data = k; tick();
    srch_en = 1'b0; tick();
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!ready && n < 40) begin n++; tick(); end
    chk(tag, n, 16);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin mkey[i] = '0; mval[i] = 1'b0; end
    @(negedge clk);

    rst = 1'b1; tick();
    chk("rst_ready", ready, 0);
    chk("rst_vec", match_vec, 0);
    rst = 1'b0;
    wait_init("init_len");

    do_search(4'h5);
    chk("post_init_match", match, 0);
    chk("post_init_vec", match_vec, 0);

    do_write(4'd2, 4'h3);
    do_write(4'd9, 4'h3);
    do_search(4'h3);
    chk("basic_vec", match_vec, 16'h0204);
    chk("basic_match", match, 1);
    chk("basic_addr", match_addr, 2);

    do_write(4'd2, 4'h7);
    do_search(4'h3);
    chk("ovw_old_vec", match_vec, 16'h0200);
    do_search(4'h7);
    chk("ovw_new_vec", match_vec, 16'h0004);

    do_write(4'd9, 4'hA);
    do_search(4'h3);
    chk("key3_gone", match, 0);
    wr_en = 1'b1; er_en = 1'b1; wr_addr = 4'd9; wr_data = 4'hB; tick();
    wr_en = 1'b0; er_en = 1'b0; tick(); tick();
    do_search(4'hB);
    chk("prio_vec", match_vec, 16'h0200);
    er_en = 1'b1; wr_addr = 4'd9; tick();
    er_en = 1'b0;
    chk("erase_ready", ready, 1);
    do_search(4'hB);
    chk("erase_match", match, 0);

    do_write(4'd3, 4'h4);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 4'h4; tick();
    wr_en = 1'b0; tick();
    srch_en = 1'b1; srch_data = 4'h4; tick();
    tick();
    chk("rbw_old", match_vec, 16'h0008);
    srch_en = 1'b0; tick();
    chk("rbw_new", match_vec, 16'h000A);

    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 4'h6; tick();
    wr_en = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    wait_init("reinit_len");
    do_search(4'h6);
    chk("midwr_6", match, 0);
    do_search(4'h4);
    chk("midwr_4", match_vec, 0);
    do_search(4'h7);
    chk("midwr_7", match, 0);

    for (int t = 0; t < 600; t++) begin
      rst       = ($urandom_range(63) == 0);
      wr_en     = ($urandom_range(3) == 0);
      er_en     = ($urandom_range(3) == 0);
      wr_addr   = 4'($urandom_range(15));
      wr_data   = 4'($urandom_range(15));
      srch_en   = ($urandom_range(1) == 0);
      srch_data = 4'($urandom_range(15));
      tick();
    end
    idle_inputs();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_core.md
CAM_CORE -- requirements
Module: cam_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, which sets the key width in bits. The memory has 2**DATA_WIDTH rows.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, which sets the entry index width. The match vector is 2**ADDR_WIDTH bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port wr_en, input, 1 bit: write request.
REQ-006 SHALL have port er_en, input, 1 bit: erase request.
REQ-007 SHALL have port wr_addr, input, ADDR_WIDTH bits: entry index used by write and erase.
REQ-008 SHALL have port wr_data, input, DATA_WIDTH bits: key to store.
REQ-009 SHALL have port ready, output, 1 bit: high when a write or erase can be accepted.
REQ-010 SHALL have port srch_en, input, 1 bit: search request.
REQ-011 SHALL have port srch_data, input, DATA_WIDTH bits: search key.
REQ-012 SHALL have port srch_valid, output, 1 bit: search result valid.
REQ-013 SHALL have port match_vec, output, 2**ADDR_WIDTH bits: one bit per entry holding the key.
REQ-014 SHALL have port match, output, 1 bit: OR of match_vec.
REQ-015 SHALL have port match_addr, output, ADDR_WIDTH bits: lowest set index of match_vec.

Function
REQ-016 SHALL store the table transposed: row k holds bit i = 1 when entry i currently holds key k.
REQ-017 SHALL keep shadow key and valid-bit registers per entry, so each entry holds at most one key.
REQ-018 SHALL implement an FSM with states INIT, IDLE, CLR_OLD and SET_NEW.
REQ-019 INIT SHALL clear one row per cycle, using a DATA_WIDTH-bit sweep counter from 0 to 2**DATA_WIDTH-1, then go to IDLE; INIT therefore lasts exactly 2**DATA_WIDTH cycles.
REQ-020 ready SHALL be 1 only in IDLE. Requests with ready=0 SHALL be ignored, not queued.
REQ-021 In IDLE, a write request (wr_en=1) SHALL latch wr_addr and wr_data and go to CLR_OLD.
REQ-022 CLR_OLD SHALL clear bit wr_addr in row shadow_key[wr_addr] if that entry is valid (otherwise no memory change), then go to SET_NEW.
REQ-023 SHALL perform SET_NEW as follows: set bit wr_addr in row wr_data; update shadow key and valid=1; go to IDLE. Write occupancy is 2 cycles, and ready returns the cycle after SET_NEW.
REQ-024 In IDLE, er_en=1 with wr_en=0 SHALL clear bit wr_addr in row shadow_key[wr_addr] (if valid) and clear valid in that same cycle. The FSM stays in IDLE and ready stays 1.
REQ-025 When wr_en and er_en are both 1, the write SHALL win and the erase is dropped.
REQ-026 Rewriting an entry with its current key SHALL leave the table unchanged after SET_NEW.
REQ-027 The search pipeline SHALL have latency 2:
- cycle N: srch_en sampled and row read;
- cycle N+1: row registered;
- cycle N+2: srch_valid=1 with match_vec, match and match_addr.
REQ-028 Search SHALL be accepted in IDLE, CLR_OLD and SET_NEW (fully pipelined, one per cycle) and ignored in INIT.
REQ-029 A search SHALL read the row contents before that cycle's memory update (read-before-write).
REQ-030 No match SHALL give match=0, match_addr=0 and match_vec=0, with srch_valid still 1.
REQ-031 srch_valid SHALL be a single-cycle pulse per accepted search.
REQ-032 Outputs SHALL be registered.

Reset
REQ-033 rst=1 at any clock SHALL:
- enter INIT with sweep counter 0;
- clear all shadow valid bits;
- set ready=0, srch_valid=0, match_vec=0, match=0, match_addr=0;
- flush in-flight search pipeline stages.
REQ-034 Reset mid-write or mid-INIT SHALL abandon the operation and restart a full INIT sweep.
REQ-035 Memory contents SHALL be treated as all-zero only after INIT completes.

Verification
REQ-036 Reset scenario: rst for 1 cycle -> ready=0 for exactly 16 cycles (default parameters), then 1; a search of key 5 afterwards returns match=0, match_vec=0.
REQ-037 Basic write/search scenario: write key 0x3 to entries 2 and 9, then search key 0x3 -> match_vec=16'h0204, match=1, match_addr=2, two cycles after srch_en.
REQ-038 Overwrite scenario: write key 0x3 to entry 2, then write key 0x7 to entry 2 -> search of 0x3 gives match=0; search of 0x7 gives match_vec=16'h0004.
REQ-039 Erase and priority scenario: after entry 9 holds 0xA, assert er_en and wr_en together for entry 9 with key 0xB -> write wins (search 0xB gives bit 9); then er_en alone for entry 9 -> search 0xB gives match=0.
REQ-040 Read-before-write scenario: search 0x4 in the SET_NEW cycle of a write of 0x4 to entry 1 -> result excludes bit 1; the next search includes bit 1.
REQ-041 Reset mid-write scenario: assert rst in the CLR_OLD cycle -> the write is lost, 16-cycle INIT restarts, and all searches miss.
